// File: rtl/write_back_cache.sv
// Direct-mapped write-back, write-allocate data cache between a core load/store port and a
// single-word request/response RAM port. Tag and data stores are 1-cycle-latency SPBRAMs.
module write_back_cache #(
    parameter int unsigned LINE_IX_BITWIDTH   = 8,
    parameter int unsigned COLUMN_IX_BITWIDTH = 2,
    localparam int unsigned TAG_BITWIDTH      = 32 - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        mem_req_valid,
    output logic        mem_req_write,
    output logic [31:0] mem_req_address,
    output logic [31:0] mem_req_data,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int unsigned LINES   = 1 << LINE_IX_BITWIDTH;
    localparam int unsigned COLUMNS = 1 << COLUMN_IX_BITWIDTH;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StLookup,
        StEvict,
        StFill,
        StReplay
    } state_e;

    state_e                          state_q;
    logic [LINE_IX_BITWIDTH-1:0]     clr_ix_q;
    logic [LINE_IX_BITWIDTH-1:0]     line_q;
    logic [TAG_BITWIDTH-1:0]         tag_q;
    logic [TAG_BITWIDTH-1:0]         old_tag_q;
    logic [COLUMN_IX_BITWIDTH-1:0]   col_q;
    logic [COLUMN_IX_BITWIDTH-1:0]   mem_col_q;
    logic                            write_q;
    logic [31:0]                     wdata_q;
    logic [31:0]                     victim_q [COLUMNS];

    logic [COLUMN_IX_BITWIDTH-1:0]   req_col;
    logic [LINE_IX_BITWIDTH-1:0]     req_line;
    logic [TAG_BITWIDTH-1:0]         req_tag;
    logic [COLUMN_IX_BITWIDTH-1:0]   next_col;
    logic [LINE_IX_BITWIDTH-1:0]     mem_line;
    logic [LINE_IX_BITWIDTH-1:0]     tag_addr;
    logic                            tag_we;
    logic [31:0]                     tag_wdata;
    logic [31:0]                     tag_rd;
    logic [31:0]                     tag_mem [LINES];
    logic [COLUMNS-1:0]              data_we;
    logic [31:0]                     data_wdata;
    logic [31:0]                     data_rd [COLUMNS];
    logic                            hit;
    logic                            victim_dirty;
    logic                            unused_bits;

    assign req_col      = req_address[2 +: COLUMN_IX_BITWIDTH];
    assign req_line     = req_address[2 + COLUMN_IX_BITWIDTH +: LINE_IX_BITWIDTH];
    assign req_tag      = req_address[31 -: TAG_BITWIDTH];
    assign next_col     = mem_col_q + 1'b1;
    assign hit          = tag_rd[TAG_BITWIDTH] && (tag_rd[TAG_BITWIDTH-1:0] == tag_q);
    assign victim_dirty = tag_rd[TAG_BITWIDTH] && tag_rd[TAG_BITWIDTH+1];
    assign unused_bits  = ^{req_address[1:0], tag_rd[31:TAG_BITWIDTH+2]};

    // In IDLE the incoming line is presented so LOOKUP sees its BRAM words one cycle later.
    assign mem_line = (state_q == StIdle) ? req_line : line_q;
    assign tag_addr = (state_q == StClear) ? clr_ix_q : mem_line;

    always_comb begin
        tag_we     = 1'b0;
        tag_wdata  = '0;
        data_we    = '0;
        data_wdata = mem_resp_data;
        if (!rst) begin
            case (state_q)
                StClear: tag_we = 1'b1;
                StLookup: begin
                    if (hit && write_q) begin
                        tag_we                       = 1'b1;
                        tag_wdata[TAG_BITWIDTH-1:0]  = tag_q;
                        tag_wdata[TAG_BITWIDTH]      = 1'b1;
                        tag_wdata[TAG_BITWIDTH+1]    = 1'b1;
                        data_we[col_q]               = 1'b1;
                        data_wdata                   = wdata_q;
                    end
                end
                StFill: begin
                    if (!mem_req_valid && mem_resp_valid) begin
                        data_we[mem_col_q] = 1'b1;
                        if (&mem_col_q) begin
                            tag_we                      = 1'b1;
                            tag_wdata[TAG_BITWIDTH-1:0] = tag_q;
                            tag_wdata[TAG_BITWIDTH]     = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[tag_addr] <= tag_wdata;
        tag_rd <= tag_mem[tag_addr];
    end

    for (genvar c = 0; c < COLUMNS; c++) begin : g_column
        logic [31:0] mem [LINES];
        logic [31:0] rd_q;
        always_ff @(posedge clk) begin
            if (data_we[c]) mem[mem_line] <= data_wdata;
            rd_q <= mem[mem_line];
        end
        assign data_rd[c] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StClear;
            clr_ix_q        <= '0;
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_write   <= 1'b0;
            mem_req_address <= '0;
            mem_req_data    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            case (state_q)
                StClear: begin
                    clr_ix_q <= clr_ix_q + 1'b1;
                    if (&clr_ix_q) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end
                end
                StIdle: begin
                    if (req_valid && req_ready) begin
                        line_q    <= req_line;
                        tag_q     <= req_tag;
                        col_q     <= req_col;
                        write_q   <= req_write;
                        wdata_q   <= req_data;
                        req_ready <= 1'b0;
                        state_q   <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        resp_valid <= 1'b1;
                        resp_data  <= write_q ? 32'h0 : data_rd[col_q];
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        for (int unsigned c = 0; c < COLUMNS; c++) victim_q[c] <= data_rd[c];
                        old_tag_q     <= tag_rd[TAG_BITWIDTH-1:0];
                        mem_col_q     <= '0;
                        mem_req_valid <= 1'b1;
                        if (victim_dirty) begin
                            state_q         <= StEvict;
                            mem_req_write   <= 1'b1;
                            mem_req_address <= {tag_rd[TAG_BITWIDTH-1:0], line_q,
                                                {COLUMN_IX_BITWIDTH{1'b0}}, 2'b00};
                            mem_req_data    <= data_rd[0];
                        end else begin
                            state_q         <= StFill;
                            mem_req_write   <= 1'b0;
                            mem_req_address <= {tag_q, line_q, {COLUMN_IX_BITWIDTH{1'b0}}, 2'b00};
                            mem_req_data    <= '0;
                        end
                    end
                end
                StEvict: begin
                    if (mem_req_valid && mem_req_ready) begin
                        if (&mem_col_q) begin
                            state_q         <= StFill;
                            mem_col_q       <= '0;
                            mem_req_write   <= 1'b0;
                            mem_req_address <= {tag_q, line_q, {COLUMN_IX_BITWIDTH{1'b0}}, 2'b00};
                            mem_req_data    <= '0;
                        end else begin
                            mem_col_q       <= next_col;
                            mem_req_address <= {old_tag_q, line_q, next_col, 2'b00};
                            mem_req_data    <= victim_q[next_col];
                        end
                    end
                end
                StFill: begin
                    // mem_req_valid low means the single outstanding read awaits its data.
                    if (mem_req_valid) begin
                        if (mem_req_ready) mem_req_valid <= 1'b0;
                    end else if (mem_resp_valid) begin
                        if (&mem_col_q) begin
                            state_q <= StReplay;
                        end else begin
                            mem_col_q       <= next_col;
                            mem_req_valid   <= 1'b1;
                            mem_req_address <= {tag_q, line_q, next_col, 2'b00};
                        end
                    end
                end
                StReplay: state_q <= StLookup;
                default:  state_q <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_cache.sv
// Directed bench for write_back_cache: a RAM model with optional stalls logs every RAM
// handshake, and a scoreboard queue holds the expected core responses.
module tb_write_back_cache;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [31:0] mem_req_address;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    write_back_cache dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_address(mem_req_address),
        .mem_req_data   (mem_req_data),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    int          total = 0;
    int          bad = 0;
    int          stall_n = 0;
    int          rd_resp_cnt = 0;
    logic [31:0] exp_q[$];
    mem_op_t     log_q[$];
    logic [31:0] ram [logic [31:0]];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return 32'h5A5A_0000 ^ a;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : def_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_mem(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] data);
        mem_op_t op;
        total++;
        assert (log_q.size() > 0) else begin
            bad++;
            $error("FAIL %s: got no RAM op want addr %h", tag, addr);
        end
        if (log_q.size() > 0) begin
            op = log_q.pop_front();
            check({tag, "_we"}, 32'(op.we), 32'(we));
            check({tag, "_addr"}, op.addr, addr);
            if (we) check({tag, "_data"}, op.data, data);
        end
    endtask

    task automatic expect_fill(input string tag, input logic [31:0] base);
        for (int c = 0; c < 4; c++) expect_mem(tag, 1'b0, base + 32'(4 * c), 32'h0);
    endtask

    task automatic send_req(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
        int n;
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_data    = d;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp, output int lat);
        exp_q.push_back(exp);
        send_req(tag, w, a, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 2000);
        check({tag, "_resp_seen"}, 32'(resp_valid), 32'h1);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready || n >= 400) break;
        end
        check({tag, "_cycles"}, 32'(n), 32'd256);
    endtask

    // RAM model: decisions at negedge take effect at the following posedge.
    logic        resp_pend = 1'b0;
    logic [31:0] resp_word;
    int          stall_cnt = 0;
    logic        held_we;
    logic [31:0] held_addr;
    logic [31:0] held_data;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            if (resp_pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = resp_word;
                resp_pend      = 1'b0;
                rd_resp_cnt++;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid && !rst) begin
                if (stall_cnt > 0) begin
                    check("stall_stable_addr", mem_req_address, held_addr);
                    check("stall_stable_data", mem_req_data, held_data);
                    check("stall_stable_we", 32'(mem_req_write), 32'(held_we));
                end
                if (stall_cnt >= stall_n) begin
                    mem_req_ready = 1'b1;
                    stall_cnt     = 0;
                    log_q.push_back('{mem_req_write, mem_req_address, mem_req_data});
                    if (mem_req_write) begin
                        ram[mem_req_address] = mem_req_data;
                    end else begin
                        resp_pend = 1'b1;
                        resp_word = ram_rd(mem_req_address);
                    end
                end else begin
                    if (stall_cnt == 0) begin
                        held_we   = mem_req_write;
                        held_addr = mem_req_address;
                        held_data = mem_req_data;
                    end
                    stall_cnt++;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    // Scoreboard: every response pops the oldest expected value.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL resp_unexpected: got %h want no response", resp_data);
                end
                if (exp_q.size() > 0) check("resp_data", resp_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int lat;
        int n;
        int nz;
        int cnt0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_data    = '0;
        ram[32'h1000] = 32'hA0;
        ram[32'h1004] = 32'hA1;
        ram[32'h1008] = 32'hA2;
        ram[32'h100C] = 32'hA3;

        // Reset and clear
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_mem_req_address", mem_req_address, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("clear");
        nz = 0;
        for (int i = 0; i < 256; i++) if (dut.tag_mem[i] != 32'h0) nz++;
        check("clear_tags_nonzero", 32'(nz), 32'h0);

        // Cold load then hit reload
        access("cold_load", 1'b0, 32'h0000_1008, 32'h0, 32'hA2, lat);
        expect_fill("cold_fill", 32'h1000);
        check("cold_extra_ops", 32'(log_q.size()), 32'h0);
        access("reload", 1'b0, 32'h0000_1008, 32'h0, 32'hA2, lat);
        check("reload_latency", 32'(lat), 32'd2);
        check("reload_no_mem", 32'(log_q.size()), 32'h0);

        // Store hit, then conflicting load evicts the dirty line
        access("store_hit", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, lat);
        check("store_hit_latency", 32'(lat), 32'd2);
        check("store_hit_no_mem", 32'(log_q.size()), 32'h0);
        access("conflict_load", 1'b0, 32'h0000_5004, 32'h0, def_word(32'h5004), lat);
        expect_mem("evict0", 1'b1, 32'h1000, 32'hA0);
        expect_mem("evict1", 1'b1, 32'h1004, 32'hDEAD_BEEF);
        expect_mem("evict2", 1'b1, 32'h1008, 32'hA2);
        expect_mem("evict3", 1'b1, 32'h100C, 32'hA3);
        expect_fill("conflict_fill", 32'h5000);
        check("conflict_extra_ops", 32'(log_q.size()), 32'h0);

        // Store miss over a clean victim: fill then merge
        access("store_miss", 1'b1, 32'h0000_2000, 32'h0000_1234, 32'h0, lat);
        expect_fill("store_miss_fill", 32'h2000);
        check("store_miss_no_evict", 32'(log_q.size()), 32'h0);
        access("store_miss_load", 1'b0, 32'h0000_2000, 32'h0, 32'h0000_1234, lat);
        check("store_miss_load_latency", 32'(lat), 32'd2);
        check("store_miss_tag_dirty", dut.tag_mem[0], 32'h0030_0002);

        // Eviction under RAM back-pressure
        stall_n = 5;
        access("stall_load", 1'b0, 32'h0000_3000, 32'h0, def_word(32'h3000), lat);
        stall_n = 0;
        expect_mem("stall_evict0", 1'b1, 32'h2000, 32'h0000_1234);
        expect_mem("stall_evict1", 1'b1, 32'h2004, def_word(32'h2004));
        expect_mem("stall_evict2", 1'b1, 32'h2008, def_word(32'h2008));
        expect_mem("stall_evict3", 1'b1, 32'h200C, def_word(32'h200C));
        expect_fill("stall_fill", 32'h3000);
        check("stall_extra_ops", 32'(log_q.size()), 32'h0);

        // Highest line index and address wrap at the top of memory
        access("max_line_load", 1'b0, 32'h0000_0FF4, 32'h0, def_word(32'h0FF4), lat);
        expect_fill("max_line_fill", 32'h0FF0);
        access("max_line_store", 1'b1, 32'h0000_0FF8, 32'h0000_55AA, 32'h0, lat);
        check("max_line_store_latency", 32'(lat), 32'd2);
        access("wrap_load", 1'b0, 32'hFFFF_FFFC, 32'h0, def_word(32'hFFFF_FFFC), lat);
        expect_mem("wrap_evict0", 1'b1, 32'h0FF0, def_word(32'h0FF0));
        expect_mem("wrap_evict1", 1'b1, 32'h0FF4, def_word(32'h0FF4));
        expect_mem("wrap_evict2", 1'b1, 32'h0FF8, 32'h0000_55AA);
        expect_mem("wrap_evict3", 1'b1, 32'h0FFC, def_word(32'h0FFC));
        expect_fill("wrap_fill", 32'hFFFF_FFF0);
        check("wrap_extra_ops", 32'(log_q.size()), 32'h0);

        // Reset in the middle of a fill
        cnt0 = rd_resp_cnt;
        send_req("abort_req", 1'b0, 32'h0000_7010, 32'h0);
        n = 0;
        while (rd_resp_cnt < cnt0 + 2 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("abort_two_resp", 32'(rd_resp_cnt - cnt0), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check("abort_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("abort_clear");
        log_q.delete();
        access("abort_reload", 1'b0, 32'h0000_7010, 32'h0, def_word(32'h7010), lat);
        expect_fill("abort_refill", 32'h7010);
        check("abort_extra_ops", 32'(log_q.size()), 32'h0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
